weight_stream_loader: RTL and testbench

- Parametrised successor to the fixed two-layer weight uploader.
- Streams pretrained biases and weight rows for any number of layers from two external synchronous memories into the network's layer weight registers.
- Uses a valid/ready handshake with backpressure, per-column masking and a single-layer reload mode.
- Sits between the weight/bias memories and the layer array, in the same position as the current uploader.

---
 rtl/weight_stream_loader_pkg.sv | 46 ++++
 rtl/weight_stream_loader.sv | 168 ++++++++++++++++
 tb/tb_weight_stream_loader.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_stream_loader_pkg.sv
// Shared types and constant helpers for the weight stream loader.
// Helpers take plain counts so they can be evaluated at elaboration time.
package weight_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        B_ISSUE,
        B_CAP,
        ROW_ISSUE,
        ROW_CAP,
        BEAT,
        DONE
    } state_t;

    localparam int unsigned MAX_MASK_W     = 4096;
    localparam int unsigned MAX_DIM_LAYERS = 32;
    localparam int unsigned DIM_W          = 16;

    // Per-layer row counts packed DIM_W bits per layer, layer 0 in the LSBs.
    typedef logic [MAX_DIM_LAYERS*DIM_W-1:0] dims_t;

    function automatic int unsigned layer_base(input int unsigned l, input dims_t rows);
        int unsigned sum;
        sum = 0;
        for (int unsigned i = 0; i < l && i < MAX_DIM_LAYERS; i++) begin
            sum += 32'(rows[i*DIM_W +: DIM_W]);
        end
        return sum;
    endfunction

    function automatic logic [MAX_MASK_W-1:0] col_mask(input int unsigned cols,
                                                       input int unsigned dw);
        logic [MAX_MASK_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_MASK_W; i++) begin
            m[i] = (i < cols * dw);
        end
        return m;
    endfunction

    function automatic logic [MAX_MASK_W-1:0] bias_mask(input int unsigned rows,
                                                        input int unsigned dw);
        return col_mask(rows, 2 * dw);
    endfunction

endpackage

// File: rtl/weight_stream_loader.sv
// Streams per-layer bias vectors and masked weight rows from synchronous
// weight/bias memories to the layer array over a valid/ready handshake.
module weight_stream_loader
    import weight_loader_pkg::*;
#(
    parameter int unsigned LAYERS        = 3,
    parameter int unsigned DATAWIDTH     = 11,
    parameter int unsigned MAX_ROWS      = 30,
    parameter int unsigned MAX_COLS      = 64,
    parameter int unsigned ROWS [LAYERS] = '{30, 10, 2},
    parameter int unsigned COLS [LAYERS] = '{64, 30, 5},
    parameter int unsigned W_ADDR_W      = 7,
    localparam int unsigned LW  = (LAYERS > 1) ? $clog2(LAYERS) : 1,
    localparam int unsigned RSW = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1,
    localparam int unsigned WW  = MAX_COLS * DATAWIDTH,
    localparam int unsigned BW  = MAX_ROWS * 2 * DATAWIDTH
) (
    input  logic                clk,
    input  logic                rst_overall,
    input  logic                start,
    input  logic                single_layer,
    input  logic [LW-1:0]       layer_req,
    input  logic                abort,
    output logic [W_ADDR_W-1:0] w_addr,
    input  logic [WW-1:0]       w_rdata,
    output logic [LW-1:0]       b_addr,
    input  logic [BW-1:0]       b_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                beat_is_bias,
    output logic [LW-1:0]       layer_select,
    output logic [RSW-1:0]      row_select,
    output logic [WW-1:0]       weight_update,
    output logic [BW-1:0]       bias_updates,
    output logic                train,
    output logic                upload_done,
    output logic                aborted,
    output logic                err_layer
);

    localparam logic [LW-1:0] LAST_LAYER = LW'(LAYERS - 1);

    function automatic dims_t pack_rows();
        dims_t p;
        p = '0;
        for (int unsigned i = 0; i < LAYERS; i++) begin
            p[i*DIM_W +: DIM_W] = DIM_W'(ROWS[i]);
        end
        return p;
    endfunction

    localparam dims_t ROWS_PK = pack_rows();

    state_t               state;
    logic                 single_mode;
    logic [LW-1:0]        cur_layer;
    logic [RSW-1:0]       row;
    logic [RSW-1:0]       row_inc;

    logic [WW-1:0]        col_mask_tab  [LAYERS];
    logic [BW-1:0]        bias_mask_tab [LAYERS];
    logic [W_ADDR_W-1:0]  base_tab      [LAYERS];
    logic [RSW-1:0]       last_row_tab  [LAYERS];

    for (genvar g = 0; g < LAYERS; g++) begin : g_tab
        localparam logic [MAX_MASK_W-1:0] CM = col_mask(COLS[g], DATAWIDTH);
        localparam logic [MAX_MASK_W-1:0] BM = bias_mask(ROWS[g], DATAWIDTH);
        assign col_mask_tab[g]  = CM[WW-1:0];
        assign bias_mask_tab[g] = BM[BW-1:0];
        assign base_tab[g]      = W_ADDR_W'(layer_base(g, ROWS_PK));
        assign last_row_tab[g]  = RSW'(ROWS[g] - 1);
    end

    assign row_inc = row + RSW'(1);

    // Addresses are registered on entry to the ISSUE states, so they are stable
    // throughout ISSUE and the 1-cycle memory read lands exactly in the CAP state.
    always_ff @(posedge clk or posedge rst_overall) begin
        if (rst_overall) begin
            state         <= IDLE;
            single_mode   <= 1'b0;
            cur_layer     <= '0;
            row           <= '0;
            w_addr        <= '0;
            b_addr        <= '0;
            out_valid     <= 1'b0;
            beat_is_bias  <= 1'b0;
            layer_select  <= '0;
            row_select    <= '0;
            weight_update <= '0;
            bias_updates  <= '0;
            train         <= 1'b0;
            upload_done   <= 1'b0;
            aborted       <= 1'b0;
            err_layer     <= 1'b0;
        end else begin
            upload_done <= 1'b0;
            aborted     <= 1'b0;
            err_layer   <= 1'b0;
            if (abort && state != IDLE) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                train     <= 1'b0;
                aborted   <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            if (single_layer && 32'(layer_req) >= LAYERS) begin
                                err_layer <= 1'b1;
                            end else begin
                                single_mode <= single_layer;
                                cur_layer   <= single_layer ? layer_req : '0;
                                b_addr      <= single_layer ? layer_req : '0;
                                row         <= '0;
                                train       <= 1'b1;
                                state       <= B_ISSUE;
                            end
                        end
                    end
                    B_ISSUE: state <= B_CAP;
                    B_CAP: begin
                        bias_updates <= b_rdata & bias_mask_tab[cur_layer];
                        beat_is_bias <= 1'b1;
                        layer_select <= cur_layer;
                        row_select   <= '0;
                        out_valid    <= 1'b1;
                        state        <= BEAT;
                    end
                    ROW_ISSUE: state <= ROW_CAP;
                    ROW_CAP: begin
                        weight_update <= w_rdata & col_mask_tab[cur_layer];
                        beat_is_bias  <= 1'b0;
                        layer_select  <= cur_layer;
                        row_select    <= row;
                        out_valid     <= 1'b1;
                        state         <= BEAT;
                    end
                    BEAT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (beat_is_bias) begin
                                w_addr <= base_tab[cur_layer] + W_ADDR_W'(row);
                                state  <= ROW_ISSUE;
                            end else if (row < last_row_tab[cur_layer]) begin
                                row    <= row_inc;
                                w_addr <= base_tab[cur_layer] + W_ADDR_W'(row_inc);
                                state  <= ROW_ISSUE;
                            end else if (!single_mode && cur_layer < LAST_LAYER) begin
                                cur_layer <= cur_layer + LW'(1);
                                b_addr    <= cur_layer + LW'(1);
                                row       <= '0;
                                state     <= B_ISSUE;
                            end else begin
                                upload_done <= 1'b1;
                                train       <= 1'b0;
                                state       <= DONE;
                            end
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_weight_stream_loader.sv
// Directed scoreboard bench for weight_stream_loader with default parameters.
module tb_weight_stream_loader;

    localparam int unsigned WW = 704;
    localparam int unsigned BW = 660;
    localparam int T_BASE [3] = '{0, 30, 40};
    localparam int T_ROWS [3] = '{30, 10, 2};
    localparam int T_COLS [3] = '{64, 30, 5};

    logic          clk = 1'b0;
    logic          rst_overall = 1'b1;
    logic          start = 1'b0;
    logic          single_layer = 1'b0;
    logic [1:0]    layer_req = '0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b1;
    logic [6:0]    w_addr;
    logic [WW-1:0] w_rdata = '0;
    logic [1:0]    b_addr;
    logic [BW-1:0] b_rdata = '0;
    logic          out_valid;
    logic          beat_is_bias;
    logic [1:0]    layer_select;
    logic [4:0]    row_select;
    logic [WW-1:0] weight_update;
    logic [BW-1:0] bias_updates;
    logic          train;
    logic          upload_done;
    logic          aborted;
    logic          err_layer;

    weight_stream_loader #(
        .LAYERS(3), .DATAWIDTH(11), .MAX_ROWS(30), .MAX_COLS(64), .W_ADDR_W(7)
    ) dut (
        .clk(clk), .rst_overall(rst_overall), .start(start), .single_layer(single_layer),
        .layer_req(layer_req), .abort(abort), .w_addr(w_addr), .w_rdata(w_rdata),
        .b_addr(b_addr), .b_rdata(b_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .beat_is_bias(beat_is_bias), .layer_select(layer_select), .row_select(row_select),
        .weight_update(weight_update), .bias_updates(bias_updates), .train(train),
        .upload_done(upload_done), .aborted(aborted), .err_layer(err_layer)
    );

    always #5 clk = ~clk;

    logic [WW-1:0] wmem [0:127];
    logic [BW-1:0] bmem [0:3];

    always @(posedge clk) begin
        w_rdata <= wmem[w_addr];
        b_rdata <= bmem[b_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic          bias;
        logic [1:0]    layer;
        logic [4:0]    row;
        logic [WW-1:0] wdata;
        logic [BW-1:0] bdata;
        logic [6:0]    waddr;
    } beat_t;

    beat_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int beats = 0;
    int done_count = 0;
    int aborted_count = 0;
    int err_count = 0;
    int first_valid_cyc = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    bit seen_first = 1'b1;

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] wmask(input int l);
        logic [WW-1:0] m;
        for (int i = 0; i < WW; i++) m[i] = (i < T_COLS[l] * 11);
        return m;
    endfunction

    function automatic logic [BW-1:0] bmask(input int l);
        logic [BW-1:0] m;
        for (int i = 0; i < BW; i++) m[i] = (i < T_ROWS[l] * 22);
        return m;
    endfunction

    task automatic push_layer(input int l);
        beat_t e;
        e.bias = 1'b1; e.layer = 2'(l); e.row = '0; e.waddr = '0;
        e.wdata = '0; e.bdata = bmem[l] & bmask(l);
        exp_q.push_back(e);
        for (int r = 0; r < T_ROWS[l]; r++) begin
            e.bias = 1'b0; e.row = 5'(r); e.bdata = '0;
            e.wdata = wmem[T_BASE[l] + r] & wmask(l);
            e.waddr = 7'(T_BASE[l] + r);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_all();
        for (int l = 0; l < 3; l++) push_layer(l);
    endtask

    task automatic do_start(input logic sl, input logic [1:0] lr);
        @(posedge clk); #1;
        start = 1'b1; single_layer = sl; layer_req = lr; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; single_layer = 1'b0; layer_req = '0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int d0;
        bit ok;
        d0 = done_count;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            if (rnd) out_ready = ($urandom_range(9, 0) >= 3);
            if (done_count != d0) ok = 1'b1;
        end
        out_ready = 1'b1;
        check("done_in_budget", ok, 1);
    endtask

    // Monitor: scoreboard pops on handshakes, stall stability, pulse counting.
    logic          stall_prev = 1'b0;
    logic [7:0]    snap_meta;
    logic [WW-1:0] snap_w;
    logic [BW-1:0] snap_b;

    always @(negedge clk) begin
        beat_t e;
        if (!seen_first && out_valid) begin
            seen_first = 1'b1;
            first_valid_cyc = cyc;
        end
        if (upload_done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (aborted) aborted_count++;
        if (err_layer) err_count++;
        if (stall_prev && out_valid) begin
            check("hold_meta", {beat_is_bias, layer_select, row_select}, snap_meta);
            check("hold_weight", weight_update, snap_w);
            check("hold_bias", bias_updates, snap_b);
        end
        stall_prev = out_valid && !out_ready;
        snap_meta  = {beat_is_bias, layer_select, row_select};
        snap_w     = weight_update;
        snap_b     = bias_updates;
        if (out_valid && out_ready && !abort) begin
            beats++;
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_bad++;
                $error("FAIL beat_expected: observed extra beat layer %0d row %0d, expected none",
                       layer_select, row_select);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("beat_kind", beat_is_bias, e.bias);
                check("beat_layer", layer_select, e.layer);
                check("beat_row", row_select, e.row);
                if (e.bias) begin
                    check("bias_data", bias_updates, e.bdata);
                    check("b_addr", b_addr, e.layer);
                end else begin
                    check("weight_data", weight_update, e.wdata);
                    check("w_addr", w_addr, e.waddr);
                end
            end
        end
    end

    initial begin
        logic [WW-1:0] tmp;
        logic [WW-1:0] exp_w;
        logic [BW-1:0] exp_b;
        int d0, a0, e0;
        bit found;

        for (int a = 0; a < 128; a++) begin
            for (int k = 0; k < 22; k++) tmp[k*32 +: 32] = $urandom;
            wmem[a] = tmp;
        end
        for (int a = 0; a < 4; a++) begin
            for (int k = 0; k < 22; k++) tmp[k*32 +: 32] = $urandom;
            bmem[a] = tmp[BW-1:0];
        end
        for (int a = 30; a < 40; a++) wmem[a] = '1;
        bmem[1] = '1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctl", {w_addr, b_addr, out_valid, beat_is_bias, layer_select, row_select,
                            train, upload_done, aborted, err_layer}, 0);
        check("reset_weight", weight_update, 0);
        check("reset_bias", bias_updates, 0);
        rst_overall = 1'b0;

        // All layers, out_ready high
        out_ready = 1'b1; beats = 0; push_all(); seen_first = 1'b0; d0 = done_count;
        do_start(1'b0, 2'd0);
        check("train_during_load", train, 1);
        wait_done(400, 1'b0);
        check("all_beats", beats, 45);
        check("all_queue_empty", exp_q.size(), 0);
        check("first_valid_latency", first_valid_cyc - start_cyc, 3);
        check("done_latency", done_cyc - first_valid_cyc, 133);
        check("train_after_done", train, 0);
        check("done_pulse_width", upload_done, 0);
        repeat (5) @(posedge clk);
        #1;
        check("done_once", done_count - d0, 1);

        // Single layer 1 with all-ones memory words
        beats = 0; push_layer(1);
        do_start(1'b1, 2'd1);
        wait_done(200, 1'b0);
        check("l1_beats", beats, 11);
        check("l1_queue_empty", exp_q.size(), 0);
        exp_w = '0; exp_w[329:0] = '1;
        exp_b = '0; exp_b[219:0] = '1;
        check("l1_col_mask", weight_update, exp_w);
        check("l1_bias_mask", bias_updates, exp_b);
        check("l1_layer_select", layer_select, 1);

        // Random backpressure plus an ignored start during the load
        beats = 0; push_all();
        do_start(1'b0, 2'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(9, 0) >= 3);
        end
        do_start(1'b1, 2'd2);
        wait_done(1500, 1'b1);
        check("rnd_beats", beats, 45);
        check("rnd_queue_empty", exp_q.size(), 0);

        // Abort coinciding with the L1 row 4 handshake
        out_ready = 1'b1; beats = 0; push_all(); d0 = done_count; a0 = aborted_count;
        do_start(1'b0, 2'd0);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk); #1;
            if (out_valid && !beat_is_bias && layer_select == 2'd1 && row_select == 5'd4)
                found = 1'b1;
        end
        check("abort_target_reached", found, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_pulse", aborted, 1);
        check("abort_valid_low", out_valid, 0);
        check("abort_train_low", train, 0);
        @(posedge clk); #1;
        check("abort_pulse_end", aborted, 0);
        repeat (20) @(posedge clk);
        #1;
        check("abort_beats", beats, 36);
        check("abort_once", aborted_count - a0, 1);
        check("abort_no_done", done_count - d0, 0);
        check("abort_queue_left", exp_q.size(), 9);
        exp_q.delete();
        beats = 0; push_all();
        do_start(1'b0, 2'd0);
        wait_done(400, 1'b0);
        check("restart_beats", beats, 45);
        check("restart_queue_empty", exp_q.size(), 0);

        // Out-of-range layer request
        beats = 0; e0 = err_count;
        do_start(1'b1, 2'd3);
        check("err_pulse", err_layer, 1);
        check("err_train_low", train, 0);
        @(posedge clk); #1;
        check("err_pulse_end", err_layer, 0);
        repeat (10) @(posedge clk);
        #1;
        check("err_once", err_count - e0, 1);
        check("err_no_beats", beats, 0);
        check("err_valid_low", out_valid, 0);

        // Asynchronous reset mid-beat while stalled
        out_ready = 1'b0; beats = 0; push_all();
        do_start(1'b0, 2'd0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk); #1;
            if (out_valid) found = 1'b1;
        end
        check("rst_beat_reached", found, 1);
        #2 rst_overall = 1'b1;
        #1;
        check("rst_mid_ctl", {w_addr, b_addr, out_valid, beat_is_bias, layer_select, row_select,
                              train, upload_done, aborted, err_layer}, 0);
        check("rst_mid_weight", weight_update, 0);
        check("rst_mid_bias", bias_updates, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_overall = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rst_no_beats", beats, 0);
        check("rst_valid_low", out_valid, 0);
        check("rst_train_low", train, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
